uart_tx_arbiter: RTL

Shares the single UART byte transmitter between NUM_REQ byte-stream requesters, such as the image pixel streamer, the status reporter and the debug echo. Arbitration is round-robin at packet granularity: a granted requester keeps the transmitter until its byte flagged req_last has been sent. The block drives the transmitter's doTransmit/TxData inputs and tracks its isBusy output to sequence one frame at a time. It also flags a transmitter that never acknowledges a request.

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that feeds one shared UART byte transmitter.
// Sequences one frame at a time off isBusy and flags a transmitter that never acknowledges.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   doTransmit,
  output logic [7:0]             TxData,
  input  logic                   isBusy,
  output logic [2:0]             grant_id,
  output logic                   active,
  output logic                   err_timeout,
  output logic [CNT_W-1:0]       byte_count
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {ARB, LOAD, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [2:0]      win;
  logic [2:0]      nxt_ptr;
  logic            found;
  logic            last_q;
  logic            hs;
  logic [3:0]      sidx;
  logic [TW-1:0]   tcnt;

  // Requester vectors padded to 8 so a 3-bit index is always an exact fit.
  logic [7:0]      valid_pad;
  logic [7:0]      last_pad;
  logic [7:0][7:0] data_pad;

  assign valid_pad = 8'(req_valid);
  assign last_pad  = 8'(req_last);
  assign data_pad  = 64'(req_data);

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    sidx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sidx = {1'b0, ptr} + 4'(i);
      if (sidx >= 4'(NUM_REQ)) sidx = sidx - 4'(NUM_REQ);
      if (!found && valid_pad[sidx[2:0]]) begin
        win   = sidx[2:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = (state == LOAD) && (grant_id == 3'(i)) && req_valid[i];
  end

  assign hs      = |req_ready;
  assign nxt_ptr = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB;
      ptr         <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      doTransmit  <= 1'b0;
      TxData      <= '0;
      last_q      <= 1'b0;
      tcnt        <= '0;
      err_timeout <= 1'b0;
      byte_count  <= '0;
    end else begin
      doTransmit <= 1'b0;
      case (state)
        // isBusy gate lets a frame cut short by reset drain before a new start.
        ARB: if (!isBusy && found) begin
          grant_id <= win;
          active   <= 1'b1;
          state    <= LOAD;
        end
        LOAD: if (hs) begin
          TxData     <= data_pad[grant_id];
          last_q     <= last_pad[grant_id];
          doTransmit <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (isBusy) begin
            byte_count <= byte_count + 1'b1;
            state      <= WAIT_DONE;
          end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
            // Lost byte: drop it and close the packet as if it were the last.
            err_timeout <= 1'b1;
            ptr         <= nxt_ptr;
            active      <= 1'b0;
            state       <= ARB;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_DONE: if (!isBusy) begin
          if (last_q) begin
            ptr    <= nxt_ptr;
            active <= 1'b0;
            state  <= ARB;
          end else begin
            state <= LOAD;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
